mips_run_controller: RTL and testbench

- Parametrised, synthesizable boot/run controller for the pipelined MIPS core. Replaces fixed-reset, fixed-cycle-count bring-up with a real sequencer.
- Streams initial images into instruction memory, data memory and register file through a valid/ready load port, then holds the core in reset.
- Releases the core and runs it under a cycle budget, detecting halt by PC stability.
- Optionally folds the architectural commit stream (register writebacks, memory stores) into a 32-bit signature for pass/fail checking.

---
 rtl/mips_run_controller.sv | 146 ++++++++++++++
 tb/tb_mips_run_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_controller.sv
// mips_run_controller: load/hold/run sequencer for the pipelined MIPS core with PC-stability halt detection.
// Commit-stream signature folding is compiled in with `define MIPS_RUNCTL_SIGNATURE_EN.
module mips_run_controller #(
    parameter int WORD_WIDTH  = 32,
    parameter int IMEM_DEPTH  = 1024,
    parameter int DMEM_DEPTH  = 1024,
    parameter int REG_DEPTH   = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int RESET_HOLD  = 2,
    parameter int HALT_STABLE = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [1:0]            ld_target,
    input  logic [WORD_WIDTH-1:0] ld_addr,
    input  logic [WORD_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  imem_we,
    output logic                  dmem_we,
    output logic                  rf_we,
    output logic [WORD_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  core_reset_n,
    input  logic [CNT_WIDTH-1:0]  cycle_budget,
    input  logic [WORD_WIDTH-1:0] PC_out,
    input  logic                  MEM_WB_RegWrite,
    input  logic [4:0]            MEM_WB_RegisterRd,
    input  logic [WORD_WIDTH-1:0] RegWriteData,
    input  logic                  EX_MEM_MemWrite,
    input  logic [WORD_WIDTH-1:0] EX_MEM_ALU_result,
    input  logic [WORD_WIDTH-1:0] EX_MEM_MemWriteData,
    output logic                  busy,
    output logic                  done,
    output logic                  halted,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [WORD_WIDTH-1:0] signature
);
    localparam int SW = $clog2(HALT_STABLE + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;
    state_t state;
    logic [CNT_WIDTH-1:0] budget, cnt_next;
    logic [WORD_WIDTH-1:0] prev_pc, sig_next;
    logic [SW-1:0] stable, stable_next;
    logic [HW-1:0] hold_cnt;
    logic go, take, hit_halt, hit_budget;
    // The first RUN cycle has no previous core PC, so it never counts as a match.
    always_comb begin
        go = start && (state == IDLE || state == DONE);
        take = state == LOAD && ld_valid;
        cnt_next = &cycle_count ? cycle_count : cycle_count + 1'b1;
        stable_next = (cycle_count != '0 && PC_out == prev_pc) ? stable + 1'b1 : '0;
        hit_halt = stable_next == SW'(HALT_STABLE - 1);
        hit_budget = cnt_next >= budget;
    end
`ifdef MIPS_RUNCTL_SIGNATURE_EN
    function automatic logic [WORD_WIDTH-1:0] fold(input logic [WORD_WIDTH-1:0] s, input logic [WORD_WIDTH-1:0] w);
        return {s[WORD_WIDTH-2:0], s[WORD_WIDTH-1]} ^ w;
    endfunction
    logic [WORD_WIDTH-1:0] sig_wb;
    always_comb begin
        sig_wb = (MEM_WB_RegWrite && MEM_WB_RegisterRd != '0) ?
                 fold(signature, RegWriteData ^ (WORD_WIDTH'(MEM_WB_RegisterRd) << 27)) : signature;
        sig_next = EX_MEM_MemWrite ? fold(sig_wb, EX_MEM_ALU_result ^ EX_MEM_MemWriteData) : sig_wb;
    end
`else
    logic unused_commit;
    assign unused_commit = ^{MEM_WB_RegWrite, MEM_WB_RegisterRd, RegWriteData,
                             EX_MEM_MemWrite, EX_MEM_ALU_result, EX_MEM_MemWriteData};
    assign sig_next = '0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ld_ready <= 1'b0;
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            rf_we <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            core_reset_n <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            halted <= 1'b0;
            timeout <= 1'b0;
            cycle_count <= '0;
            signature <= '0;
            budget <= '0;
            prev_pc <= '0;
            stable <= '0;
            hold_cnt <= '0;
        end else begin
            imem_we <= take && ld_target == 2'd0;
            dmem_we <= take && ld_target == 2'd1;
            rf_we <= take && ld_target == 2'd2;
            prev_pc <= PC_out;
            if (take) begin
                wr_data <= ld_data;
                wr_addr <= ld_target == 2'd0 ? ld_addr % WORD_WIDTH'(IMEM_DEPTH) :
                           ld_target == 2'd1 ? ld_addr % WORD_WIDTH'(DMEM_DEPTH) :
                           ld_target == 2'd2 ? ld_addr % WORD_WIDTH'(REG_DEPTH) : ld_addr;
            end
            if (go) begin
                state <= LOAD;
                ld_ready <= 1'b1;
                busy <= 1'b1;
                done <= 1'b0;
                core_reset_n <= 1'b0;
                halted <= 1'b0;
                timeout <= 1'b0;
                cycle_count <= '0;
                signature <= '0;
                budget <= cycle_budget;
            end else if (take && ld_last) begin
                state <= HOLD;
                ld_ready <= 1'b0;
                hold_cnt <= '0;
            end else if (state == HOLD) begin
                if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                    state <= RUN;
                    core_reset_n <= 1'b1;
                    stable <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else if (state == RUN) begin
                cycle_count <= cnt_next;
                stable <= stable_next;
                // Halt takes priority when it coincides with budget exhaustion.
                if (hit_halt || hit_budget) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    halted <= hit_halt;
                    timeout <= !hit_halt;
                end else begin
                    signature <= sig_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller: directed + randomized bench for mips_run_controller with a
// sequence-level reference model (halt/timeout cycle computed from the whole PC trace).
module tb_mips_run_controller;
    localparam int W = 32, ID = 1024, DD = 1024, RD = 32, CW = 16, RH = 2, HS = 4;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [1:0] ld_target = '0;
    logic [W-1:0] ld_addr = '0, ld_data = '0, PC_out = '0;
    logic [W-1:0] RegWriteData = '0, EX_MEM_ALU_result = '0, EX_MEM_MemWriteData = '0;
    logic MEM_WB_RegWrite = 1'b0, EX_MEM_MemWrite = 1'b0;
    logic [4:0] MEM_WB_RegisterRd = '0;
    logic [CW-1:0] cycle_budget = '0;
    logic ld_ready, imem_we, dmem_we, rf_we, core_reset_n, busy, done, halted, timeout;
    logic [W-1:0] wr_addr, wr_data, signature;
    logic [CW-1:0] cycle_count;
    int checks = 0, errors = 0;

    typedef struct packed {logic [1:0] t; logic [31:0] a; logic [31:0] d;} beat_t;
    beat_t bq[$];
    logic [31:0] pcs[1:512], wbd[1:512], sa[1:512], sd[1:512];
    logic [4:0] rdv[1:512];
    logic wbe[1:512], ste[1:512];

    always #5 clk = ~clk;

    mips_run_controller #(.WORD_WIDTH(W), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .REG_DEPTH(RD),
                          .CNT_WIDTH(CW), .RESET_HOLD(RH), .HALT_STABLE(HS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_target(ld_target), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we), .dmem_we(dmem_we), .rf_we(rf_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_reset_n(core_reset_n), .cycle_budget(cycle_budget), .PC_out(PC_out),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_RegisterRd(MEM_WB_RegisterRd),
        .RegWriteData(RegWriteData), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_MemWriteData(EX_MEM_MemWriteData),
        .busy(busy), .done(done), .halted(halted), .timeout(timeout),
        .cycle_count(cycle_count), .signature(signature)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] w);
        return ((s << 1) | (s >> 31)) ^ w;
    endfunction

    function automatic logic [31:0] wrap(input logic [1:0] t, input logic [31:0] a);
        return t == 2'd0 ? a % 32'(ID) : t == 2'd1 ? a % 32'(DD) : a % 32'(RD);
    endfunction

    task automatic chk_reset(input string tag);
        chk1({tag, "_ready"}, ld_ready, 1'b0);
        chk1({tag, "_imem"}, imem_we, 1'b0);
        chk1({tag, "_dmem"}, dmem_we, 1'b0);
        chk1({tag, "_rf"}, rf_we, 1'b0);
        chk({tag, "_waddr"}, wr_addr, 32'h0);
        chk({tag, "_wdata"}, wr_data, 32'h0);
        chk1({tag, "_crn"}, core_reset_n, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_halted"}, halted, 1'b0);
        chk1({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_cnt"}, 32'(cycle_count), 32'h0);
        chk({tag, "_sig"}, signature, 32'h0);
    endtask

    task automatic random_beats();
        int n;
        bq.delete();
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) bq.push_back({2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)});
    endtask

    task automatic do_load(input logic [CW-1:0] bud);
        cycle_budget = bud;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycle_budget = CW'($urandom);
        chk1("load_ready", ld_ready, 1'b1);
        chk1("load_crn", core_reset_n, 1'b0);
        chk1("load_busy", busy, 1'b1);
        chk1("load_done", done, 1'b0);
        chk1("load_halted", halted, 1'b0);
        chk1("load_timeout", timeout, 1'b0);
        chk("load_cnt", 32'(cycle_count), 32'h0);
        chk("load_sig", signature, 32'h0);
        foreach (bq[j]) begin
            if ($urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                tick();
                chk1("bubble_we", imem_we | dmem_we | rf_we, 1'b0);
            end
            ld_valid = 1'b1;
            ld_target = bq[j].t;
            ld_addr = bq[j].a;
            ld_data = bq[j].d;
            ld_last = (j == bq.size() - 1);
            tick();
            ld_valid = 1'b0;
            ld_last = 1'b0;
            chk1("imem_we", imem_we, bq[j].t == 2'd0);
            chk1("dmem_we", dmem_we, bq[j].t == 2'd1);
            chk1("rf_we", rf_we, bq[j].t == 2'd2);
            if (bq[j].t != 2'd3) begin
                chk("wr_addr", wr_addr, wrap(bq[j].t, bq[j].a));
                chk("wr_data", wr_data, bq[j].d);
            end
        end
        chk1("hold_ready", ld_ready, 1'b0);
        chk1("hold_crn", core_reset_n, 1'b0);
        for (int h = 1; h < RH; h++) begin
            tick();
            chk1("hold_crn", core_reset_n, 1'b0);
            chk1("hold_we", imem_we | dmem_we | rf_we, 1'b0);
        end
        tick();
        chk1("run_crn", core_reset_n, 1'b1);
        chk1("run_busy", busy, 1'b1);
    endtask

    // mode 0: walk to 0x10 and spin; 1: increment forever; 2: random repeats; 3: directed commits
    task automatic run_case(input logic [CW-1:0] bud, input int mode, input int glitch);
        int tmo_i, halt_i, end_i, lim;
        logic hexp;
        logic [31:0] s;
        tmo_i = (bud == 0) ? 1 : int'(bud);
        lim = tmo_i + 2;
        for (int i = 1; i <= lim; i++) begin
            pcs[i] = mode == 0 ? ((i < 5) ? 32'(4 * (i - 1)) : 32'h10) :
                     mode == 2 ? ((i == 1) ? 32'($urandom) : ($urandom_range(0, 1) == 0 ? pcs[i-1] : pcs[i-1] + 4)) :
                     32'h400 + 32'(4 * i);
            wbe[i] = mode == 3 ? (i == 2) : 1'($urandom);
            rdv[i] = mode == 3 ? 5'd8 : 5'($urandom);
            wbd[i] = mode == 3 ? 32'h5 : 32'($urandom);
            ste[i] = mode == 3 ? (i == 3) : 1'($urandom);
            sa[i] = mode == 3 ? 32'h4 : 32'($urandom);
            sd[i] = mode == 3 ? 32'h9 : 32'($urandom);
        end
        halt_i = 0;
        for (int i = HS; i <= lim && halt_i == 0; i++) begin
            bit same = 1'b1;
            for (int k = 1; k < HS; k++) if (pcs[i-k] != pcs[i]) same = 1'b0;
            if (same) halt_i = i;
        end
        hexp = halt_i != 0 && halt_i <= tmo_i;
        end_i = hexp ? halt_i : tmo_i;
        s = 32'h0;
`ifdef MIPS_RUNCTL_SIGNATURE_EN
        for (int i = 1; i < end_i; i++) begin
            if (wbe[i] && rdv[i] != 0) s = fold(s, wbd[i] ^ ({27'b0, rdv[i]} << 27));
            if (ste[i]) s = fold(s, sa[i] ^ sd[i]);
        end
`endif
        for (int i = 1; i <= end_i; i++) begin
            PC_out = pcs[i];
            MEM_WB_RegWrite = wbe[i];
            MEM_WB_RegisterRd = rdv[i];
            RegWriteData = wbd[i];
            EX_MEM_MemWrite = ste[i];
            EX_MEM_ALU_result = sa[i];
            EX_MEM_MemWriteData = sd[i];
            start = (i == glitch);
            tick();
            start = 1'b0;
            if (i < end_i) begin
                chk1("run_done", done, 1'b0);
                chk1("run_crn", core_reset_n, 1'b1);
                chk("run_cnt", 32'(cycle_count), 32'(i));
            end
        end
        chk1("end_done", done, 1'b1);
        chk1("end_busy", busy, 1'b0);
        chk1("end_halted", halted, hexp);
        chk1("end_timeout", timeout, !hexp);
        chk1("end_crn", core_reset_n, 1'b1);
        chk("end_cnt", 32'(cycle_count), 32'(end_i));
        chk("end_sig", signature, s);
        for (int f = 0; f < 2; f++) begin
            PC_out = 32'($urandom);
            MEM_WB_RegWrite = 1'b1;
            MEM_WB_RegisterRd = 5'd3;
            RegWriteData = 32'($urandom);
            EX_MEM_MemWrite = 1'b1;
            ld_valid = 1'b1;
            ld_target = 2'd0;
            tick();
            ld_valid = 1'b0;
            chk1("frozen_we", imem_we, 1'b0);
            chk1("frozen_done", done, 1'b1);
            chk("frozen_cnt", 32'(cycle_count), 32'(end_i));
            chk("frozen_sig", signature, s);
        end
        MEM_WB_RegWrite = 1'b0;
        EX_MEM_MemWrite = 1'b0;
    endtask

    initial begin
        tick();
        chk_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;
        // ld_valid in IDLE must be ignored
        ld_valid = 1'b1;
        ld_target = 2'd1;
        ld_addr = 32'h55;
        ld_data = 32'hABCD;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_reset("idle_ld");
        end
        ld_valid = 1'b0;
        bq.delete();
        bq.push_back({2'd0, 32'd0, 32'h20080005});
        bq.push_back({2'd1, 32'd1025, 32'hDEADBEEF});
        bq.push_back({2'd2, 32'd9, 32'h7});
        do_load(16'd100);
        run_case(16'd100, 0, 0);
        random_beats();
        do_load(16'd75);
        run_case(16'd75, 1, 3);
        random_beats();
        do_load(16'd0);
        run_case(16'd0, 1, 0);
        random_beats();
        do_load(16'd8);
        run_case(16'd8, 0, 0);
        random_beats();
        do_load(16'd10);
        run_case(16'd10, 3, 0);
        for (int r = 0; r < 5; r++) begin
            logic [CW-1:0] b;
            b = CW'($urandom_range(1, 40));
            random_beats();
            do_load(b);
            run_case(b, 2, int'($urandom_range(0, 3)));
        end
        random_beats();
        do_load(16'd50);
        for (int c = 0; c < 5; c++) begin
            PC_out = 32'h100 + 32'(4 * c);
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_reset("post_rst");
        random_beats();
        do_load(16'd30);
        run_case(16'd30, 2, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
